mux4_rr_select: RTL and testbench



---
 rtl/mux4_pkg.sv | 19 +
 rtl/rr_pick4.sv | 29 ++
 rtl/mux4_rr_select.sv | 139 +++++++++++++
 tb/tb_mux4_rr_select.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/mux4_pkg.sv
// Shared definitions for the mux4 round-robin select slice: state encodings,
// channel geometry and the stats counter width.
package mux4_pkg;

    localparam logic IDLE  = 1'b0;
    localparam logic GRANT = 1'b1;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned SEL_W  = 2;
    localparam int unsigned STAT_W = 16;

    function automatic logic [NUM_CH-1:0] sel_to_onehot(input logic [SEL_W-1:0] sel);
        logic [NUM_CH-1:0] oh;
        oh      = '0;
        oh[sel] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational rotating priority pick: first set bit of req scanning from ptr upward,
// wrapping 3 -> 0.
module rr_pick4
    import mux4_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic [SEL_W-1:0]  idx,
    output logic              any
);

    logic             found;
    logic [SEL_W-1:0] cand;

    always_comb begin
        idx   = ptr;
        found = 1'b0;
        cand  = ptr;
        for (int k = 0; k < int'(NUM_CH); k++) begin
            cand = ptr + SEL_W'(k);
            if (!found && req[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
        any = |req;
    end

endmodule

// File: rtl/mux4_rr_select.sv
// Round-robin arbiter driving the select of a 4:1 mux, with bounded bursts per grant.
// Optional per-channel grant counters are enabled with MUX4_RR_STATS_EN.
module mux4_rr_select
    import mux4_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 4,
    parameter int unsigned HOLD_W   = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        req,
    input  logic                     ready,
`ifdef MUX4_RR_STATS_EN
    input  logic                     stats_clr,
    output logic [NUM_CH*STAT_W-1:0] grant_cnt,
`endif
    output logic [SEL_W-1:0]         s,
    output logic [NUM_CH-1:0]        grant,
    output logic                     valid
);

    localparam logic [HOLD_W-1:0] HoldLast = HOLD_W'(MAX_HOLD - 1);

    logic              state_q, state_d;
    logic [SEL_W-1:0]  ptr_q, ptr_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [SEL_W-1:0]  s_q, s_d;
    logic [NUM_CH-1:0] grant_q, grant_d;
    logic              valid_q, valid_d;

    logic [NUM_CH-1:0] pick_req;
    logic [SEL_W-1:0]  pick_ptr;
    logic [SEL_W-1:0]  pick_idx;
    logic              pick_any;
    logic              release_now;

    // One picker serves both decisions; in GRANT the current channel is masked out.
    always_comb begin
        if (state_q == GRANT) begin
            pick_req = req & ~grant_q;
            pick_ptr = s_q + SEL_W'(1);
        end else begin
            pick_req = req;
            pick_ptr = ptr_q;
        end
    end

    rr_pick4 u_pick (
        .req (pick_req),
        .ptr (pick_ptr),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign release_now = (state_q == GRANT) && (!req[s_q] || (ready && (hold_q == HoldLast)));

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        s_d     = s_q;
        grant_d = grant_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: begin
                grant_d = '0;
                valid_d = 1'b0;
                if (pick_any) begin
                    s_d     = pick_idx;
                    grant_d = sel_to_onehot(pick_idx);
                    valid_d = 1'b1;
                    hold_d  = '0;
                    state_d = GRANT;
                end
            end
            default: begin
                if (release_now) begin
                    ptr_d  = s_q + SEL_W'(1);
                    hold_d = '0;
                    if (pick_any) begin
                        s_d     = pick_idx;
                        grant_d = sel_to_onehot(pick_idx);
                    end else if (!req[s_q]) begin
                        grant_d = '0;
                        valid_d = 1'b0;
                        state_d = IDLE;
                    end
                end else if (ready) begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            hold_q  <= '0;
            s_q     <= '0;
            grant_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            s_q     <= s_d;
            grant_q <= grant_d;
            valid_q <= valid_d;
        end
    end

    assign s     = s_q;
    assign grant = grant_q;
    assign valid = valid_q;

`ifdef MUX4_RR_STATS_EN
    logic              issue;
    logic [STAT_W-1:0] cnt_q [NUM_CH];

    // A grant is issued whenever the next state holds a grant decided this edge.
    assign issue = valid_d && ((state_q == IDLE) || release_now);

    always_ff @(posedge clk) begin
        if (!rst_n || stats_clr) begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                cnt_q[i] <= '0;
            end
        end else if (issue) begin
            cnt_q[s_d] <= cnt_q[s_d] + STAT_W'(1);
        end
    end

    for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_cnt
        assign grant_cnt[STAT_W*g +: STAT_W] = cnt_q[g];
    end
`endif

endmodule

// File: tb/tb_mux4_rr_select.sv
// Self-checking bench for mux4_rr_select: directed vector table, corner sequences and a
// randomized run against a transfer-counting reference model.
module tb_mux4_rr_select;

    localparam int unsigned MAX_HOLD = 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       ready = 1'b0;
    logic [3:0] req   = 4'b0000;
    logic [1:0] s;
    logic [3:0] grant;
    logic       valid;
`ifdef MUX4_RR_STATS_EN
    logic        stats_clr = 1'b0;
    logic [63:0] grant_cnt;
`endif

    mux4_rr_select #(
        .MAX_HOLD (MAX_HOLD),
        .HOLD_W   (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .ready     (ready),
`ifdef MUX4_RR_STATS_EN
        .stats_clr (stats_clr),
        .grant_cnt (grant_cnt),
`endif
        .s         (s),
        .grant     (grant),
        .valid     (valid)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: busy flag, granted channel, transfers taken in this burst.
    bit          m_busy = 1'b0;
    int          m_ch   = 0;
    int          m_ptr  = 0;
    int          m_cnt  = 0;
    int          m_s    = 0;
    logic [15:0] m_stats [4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit scan(input logic [3:0] r, input int from, output int idx);
        idx = 0;
        for (int k = 0; k < 4; k++) begin
            if (r[(from + k) % 4]) begin
                idx = (from + k) % 4;
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    task automatic model_step();
        int         nxt;
        bit         issued;
        logic [3:0] others;
        issued = 1'b0;
        if (!rst_n) begin
            m_busy = 1'b0;
            m_ch   = 0;
            m_ptr  = 0;
            m_cnt  = 0;
            m_s    = 0;
            for (int i = 0; i < 4; i++) m_stats[i] = '0;
            return;
        end
        if (!m_busy) begin
            if (scan(req, m_ptr, nxt)) begin
                m_busy = 1'b1;
                m_ch   = nxt;
                m_cnt  = 0;
                issued = 1'b1;
            end
        end else if (req[m_ch] && !(ready && (m_cnt + 1 == int'(MAX_HOLD)))) begin
            if (ready) m_cnt++;
        end else begin
            others       = req;
            others[m_ch] = 1'b0;
            m_ptr        = (m_ch + 1) % 4;
            m_cnt        = 0;
            if (scan(others, m_ptr, nxt)) begin
                m_ch   = nxt;
                issued = 1'b1;
            end else if (req[m_ch]) begin
                issued = 1'b1;
            end else begin
                m_busy = 1'b0;
            end
        end
        if (m_busy) m_s = m_ch;
`ifdef MUX4_RR_STATS_EN
        if (stats_clr) begin
            for (int i = 0; i < 4; i++) m_stats[i] = '0;
        end else if (issued) begin
            m_stats[m_ch] = m_stats[m_ch] + 16'd1;
        end
`else
        if (issued) m_stats[m_ch] = m_stats[m_ch] + 16'd1;
`endif
    endtask

    task automatic cycle(input logic r, input logic [3:0] q, input logic rd);
        rst_n = r;
        req   = q;
        ready = rd;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic check_model(input string tag);
        logic [3:0] exp_grant;
        exp_grant = m_busy ? 4'(1 << m_ch) : 4'b0000;
        check({tag, "_valid"}, 64'(valid), 64'(m_busy));
        check({tag, "_grant"}, 64'(grant), 64'(exp_grant));
        check({tag, "_s"}, 64'(s), 64'(m_s));
        check({tag, "_onehot0"}, 64'($onehot0(grant)), 64'd1);
`ifdef MUX4_RR_STATS_EN
        for (int i = 0; i < 4; i++) begin
            check({tag, "_grant_cnt"}, 64'(grant_cnt[16*i +: 16]), 64'(m_stats[i]));
        end
`endif
    endtask

    typedef struct {
        logic       rst_n;
        logic [3:0] req;
        logic       ready;
        logic       valid;
        logic [3:0] grant;
        logic [1:0] s;
    } vec_t;

    vec_t vecs [20];

    initial begin
        int  waited;
        bit  seen3;
        logic [3:0] rq;

        for (int i = 0; i < 4; i++) m_stats[i] = '0;

        // rst, req, ready -> valid, grant, s (MAX_HOLD = 4)
        vecs[0]  = '{1'b0, 4'b1111, 1'b1, 1'b0, 4'b0000, 2'd0};
        vecs[1]  = '{1'b0, 4'b1111, 1'b1, 1'b0, 4'b0000, 2'd0};
        vecs[2]  = '{1'b1, 4'b1111, 1'b1, 1'b1, 4'b0001, 2'd0};
        vecs[3]  = '{1'b1, 4'b1111, 1'b1, 1'b1, 4'b0001, 2'd0};
        vecs[4]  = '{1'b1, 4'b1111, 1'b1, 1'b1, 4'b0001, 2'd0};
        vecs[5]  = '{1'b1, 4'b1111, 1'b1, 1'b1, 4'b0001, 2'd0};
        vecs[6]  = '{1'b1, 4'b1111, 1'b1, 1'b1, 4'b0010, 2'd1};
        vecs[7]  = '{1'b1, 4'b1111, 1'b1, 1'b1, 4'b0010, 2'd1};
        vecs[8]  = '{1'b1, 4'b1111, 1'b1, 1'b1, 4'b0010, 2'd1};
        vecs[9]  = '{1'b1, 4'b1101, 1'b1, 1'b1, 4'b0100, 2'd2};
        vecs[10] = '{1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'd2};
        vecs[11] = '{1'b1, 4'b0100, 1'b1, 1'b1, 4'b0100, 2'd2};
        vecs[12] = '{1'b1, 4'b0100, 1'b1, 1'b1, 4'b0100, 2'd2};
        vecs[13] = '{1'b1, 4'b0100, 1'b1, 1'b1, 4'b0100, 2'd2};
        vecs[14] = '{1'b1, 4'b0100, 1'b1, 1'b1, 4'b0100, 2'd2};
        vecs[15] = '{1'b1, 4'b0100, 1'b1, 1'b1, 4'b0100, 2'd2};
        vecs[16] = '{1'b1, 4'b0100, 1'b0, 1'b1, 4'b0100, 2'd2};
        vecs[17] = '{1'b1, 4'b1000, 1'b0, 1'b1, 4'b1000, 2'd3};
        vecs[18] = '{1'b0, 4'b1000, 1'b1, 1'b0, 4'b0000, 2'd0};
        vecs[19] = '{1'b1, 4'b0010, 1'b1, 1'b1, 4'b0010, 2'd1};

        for (int i = 0; i < 20; i++) begin
            cycle(vecs[i].rst_n, vecs[i].req, vecs[i].ready);
            check($sformatf("vec%0d_valid", i), 64'(valid), 64'(vecs[i].valid));
            check($sformatf("vec%0d_grant", i), 64'(grant), 64'(vecs[i].grant));
            check($sformatf("vec%0d_s", i), 64'(s), 64'(vecs[i].s));
        end

        // Full contention: bursts of MAX_HOLD per channel, valid never drops.
        for (int i = 0; i < 24; i++) begin
            cycle(1'b1, 4'b1111, 1'b1);
            check_model("contend");
        end

        // Backpressure mid-burst, then completion of the remaining transfers.
        cycle(1'b1, 4'b1111, 1'b1);
        check_model("bp_pre");
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 4'b1111, 1'b0);
            check_model("bp_stall");
        end
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 4'b1111, 1'b1);
            check_model("bp_resume");
        end

        // Reset during a channel-3 burst.
        waited = 0;
        seen3  = 1'b0;
        while (!seen3 && waited < 40) begin
            cycle(1'b1, 4'b1111, 1'b1);
            waited++;
            seen3 = (grant == 4'b1000);
        end
        check("wait_ch3_granted", 64'(seen3), 64'd1);
        cycle(1'b0, 4'b1111, 1'b1);
        check("midrst_valid", 64'(valid), 64'd0);
        check("midrst_s", 64'(s), 64'd0);
        check("midrst_grant", 64'(grant), 64'd0);
`ifdef MUX4_RR_STATS_EN
        check("midrst_grant_cnt", grant_cnt, 64'd0);
`endif
        cycle(1'b1, 4'b1111, 1'b1);
        check_model("after_rst");

        // Randomized traffic with occasional resets and (if present) counter clears.
        for (int i = 0; i < 3000; i++) begin
            rq = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) rq = 4'b1111;
`ifdef MUX4_RR_STATS_EN
            stats_clr = ($urandom_range(0, 63) == 0);
`endif
            cycle(($urandom_range(0, 127) != 0), rq, ($urandom_range(0, 3) != 0));
            check_model("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
